// File: rtl/dafx_pkg.sv
// Shared types and helpers for the audio mixer control blocks.
package dafx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CH_REQ,
        ST_CH_RSP,
        ST_OUT_REQ,
        ST_OUT_RSP,
        ST_DAC_L,
        ST_DAC_R
    } mix_sched_state_t;

    localparam int SAT_W = 64;

    typedef struct packed {
        logic [SAT_W-1:0] sat_value;
        logic             clipped;
    } sat_result_t;

    // Clamp a signed value into the signed range of 'width' bits.
    function automatic sat_result_t sat_signed(input logic signed [SAT_W-1:0] value,
                                               input int                      width);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_result_t             res;
        one   = SAT_W'(1);
        max_v = (one <<< (width - 1)) - one;
        min_v = ~max_v;
        if (value > max_v) begin
            res.sat_value = max_v;
            res.clipped   = 1'b1;
        end else if (value < min_v) begin
            res.sat_value = min_v;
            res.clipped   = 1'b1;
        end else begin
            res.sat_value = value;
            res.clipped   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/mixer_frame_scheduler.sv
// Per-frame mixer sequencer: walks every channel through one shared external
// multiplier, sums into left/right by pan, applies the master gain, saturates
// to the DAC width and streams the stereo frame.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for fs_strobe; snapshot taken on the strobe
// ST_CH_REQ  | channel multiply request held until mul_req_ready
// ST_CH_RSP  | waiting for channel product; accumulate by pan
// ST_OUT_REQ | master-gain multiply request (left first, then right)
// ST_OUT_RSP | waiting for master-gain product; saturate into out_l/out_r
// ST_DAC_L   | left sample offered to the DAC
// ST_DAC_R   | right sample offered to the DAC (dac_last = 1)
module mixer_frame_scheduler
    import dafx_pkg::*;
#(
    parameter int AUDIO_WIDTH_P    = 24,
    parameter int GAIN_WIDTH_P     = 32,
    parameter int Q_BITS_P         = 16,
    parameter int NR_OF_CHANNELS_P = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     fs_strobe,
    input  logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] channel_data,
    input  logic [NR_OF_CHANNELS_P*GAIN_WIDTH_P-1:0]  cr_channel_gain,
    input  logic [NR_OF_CHANNELS_P-1:0]               cr_channel_pan,
    input  logic [GAIN_WIDTH_P-1:0]                   cr_output_gain,
    input  logic                                     cmd_clear_status,
    output logic                                     mul_req_valid,
    input  logic                                     mul_req_ready,
    output logic [GAIN_WIDTH_P-1:0]                   mul_req_a,
    output logic [GAIN_WIDTH_P-1:0]                   mul_req_b,
    input  logic                                     mul_rsp_valid,
    input  logic [GAIN_WIDTH_P-1:0]                   mul_rsp_data,
    output logic [AUDIO_WIDTH_P-1:0]                  dac_data,
    output logic                                     dac_valid,
    input  logic                                     dac_ready,
    output logic                                     dac_last,
    output logic                                     busy,
    output logic                                     sr_out_clip,
    output logic                                     sr_frame_overrun
);
    localparam int AW    = AUDIO_WIDTH_P;
    localparam int GW    = GAIN_WIDTH_P;
    localparam int N     = NR_OF_CHANNELS_P;
    localparam int ACC_W = GW + $clog2(N) + 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    mix_sched_state_t        state_q, state_d;
    logic [N*AW-1:0]         data_q, data_d;
    logic [N*GW-1:0]         gain_q, gain_d;
    logic [N-1:0]            pan_q, pan_d;
    logic [GW-1:0]           ogain_q, ogain_d;
    logic [IDX_W-1:0]        ch_idx_q, ch_idx_d;
    logic                    side_q, side_d;
    logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d, prod_ext;
    logic [AW-1:0]           out_l_q, out_l_d, out_r_q, out_r_d;
    logic                    req_valid_q, req_valid_d;
    logic [GW-1:0]           req_a_q, req_a_d, req_b_q, req_b_d;
    logic [AW-1:0]           dac_data_q, dac_data_d;
    logic                    dac_valid_q, dac_valid_d, dac_last_q, dac_last_d;
    logic                    busy_q, busy_d;
    logic                    clip_q, clip_d, overrun_q, overrun_d;
    logic                    clip_set;
    sat_result_t             sat_acc, sat_out;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        gain_d      = gain_q;
        pan_d       = pan_q;
        ogain_d     = ogain_q;
        ch_idx_d    = ch_idx_q;
        side_d      = side_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        req_a_d     = req_a_q;
        req_b_d     = req_b_q;
        dac_data_d  = dac_data_q;
        clip_set    = 1'b0;
        prod_ext    = ACC_W'($signed(mul_rsp_data));
        sat_out     = sat_signed(SAT_W'($signed(mul_rsp_data)), AW);

        case (state_q)
            ST_IDLE: begin
                if (fs_strobe) begin
                    data_d   = channel_data;
                    gain_d   = cr_channel_gain;
                    pan_d    = cr_channel_pan;
                    ogain_d  = cr_output_gain;
                    acc_l_d  = '0;
                    acc_r_d  = '0;
                    ch_idx_d = '0;
                    state_d  = ST_CH_REQ;
                end
            end
            ST_CH_REQ: begin
                if (mul_req_ready) state_d = ST_CH_RSP;
            end
            ST_CH_RSP: begin
                if (mul_rsp_valid) begin
                    if (pan_q[ch_idx_q]) acc_r_d = acc_r_q + prod_ext;
                    else                 acc_l_d = acc_l_q + prod_ext;
                    if (ch_idx_q == IDX_W'(N - 1)) begin
                        side_d  = 1'b0;
                        state_d = ST_OUT_REQ;
                    end else begin
                        ch_idx_d = ch_idx_q + IDX_W'(1);
                        state_d  = ST_CH_REQ;
                    end
                end
            end
            ST_OUT_REQ: begin
                if (mul_req_ready) state_d = ST_OUT_RSP;
            end
            ST_OUT_RSP: begin
                if (mul_rsp_valid) begin
                    clip_set = sat_out.clipped;
                    if (!side_q) begin
                        out_l_d = sat_out.sat_value[AW-1:0];
                        side_d  = 1'b1;
                        state_d = ST_OUT_REQ;
                    end else begin
                        out_r_d = sat_out.sat_value[AW-1:0];
                        state_d = ST_DAC_L;
                    end
                end
            end
            ST_DAC_L: begin
                if (dac_ready) state_d = ST_DAC_R;
            end
            ST_DAC_R: begin
                if (dac_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Operands are loaded only on entry to a request state, so they stay
        // stable for the whole stall.
        sat_acc = sat_signed(SAT_W'(side_d ? acc_r_d : acc_l_d), GW);
        if (state_d == ST_CH_REQ && state_q != ST_CH_REQ) begin
            req_a_d = GW'($signed(data_d[ch_idx_d*AW +: AW]));
            req_b_d = gain_d[ch_idx_d*GW +: GW];
        end
        if (state_d == ST_OUT_REQ && state_q != ST_OUT_REQ) begin
            req_a_d  = sat_acc.sat_value[GW-1:0];
            req_b_d  = ogain_d;
            clip_set = clip_set | sat_acc.clipped;
        end
        if (state_d == ST_DAC_L) dac_data_d = out_l_d;
        if (state_d == ST_DAC_R) dac_data_d = out_r_d;

        req_valid_d = (state_d == ST_CH_REQ) || (state_d == ST_OUT_REQ);
        dac_valid_d = (state_d == ST_DAC_L) || (state_d == ST_DAC_R);
        dac_last_d  = (state_d == ST_DAC_R);
        busy_d      = (state_d != ST_IDLE);

        // Sticky flags: a set in the same cycle as a clear wins.
        clip_d    = clip_set ? 1'b1 : (cmd_clear_status ? 1'b0 : clip_q);
        overrun_d = (fs_strobe && state_q != ST_IDLE) ? 1'b1 :
                    (cmd_clear_status ? 1'b0 : overrun_q);
    end

    // State, snapshot, accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            gain_q      <= '0;
            pan_q       <= '0;
            ogain_q     <= '0;
            ch_idx_q    <= '0;
            side_q      <= 1'b0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            req_valid_q <= 1'b0;
            req_a_q     <= '0;
            req_b_q     <= '0;
            dac_data_q  <= '0;
            dac_valid_q <= 1'b0;
            dac_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            clip_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            gain_q      <= gain_d;
            pan_q       <= pan_d;
            ogain_q     <= ogain_d;
            ch_idx_q    <= ch_idx_d;
            side_q      <= side_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            req_valid_q <= req_valid_d;
            req_a_q     <= req_a_d;
            req_b_q     <= req_b_d;
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
            dac_last_q  <= dac_last_d;
            busy_q      <= busy_d;
            clip_q      <= clip_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mul_req_valid    = req_valid_q;
    assign mul_req_a        = req_a_q;
    assign mul_req_b        = req_b_q;
    assign dac_data         = dac_data_q;
    assign dac_valid        = dac_valid_q;
    assign dac_last         = dac_last_q;
    assign busy             = busy_q;
    assign sr_out_clip      = clip_q;
    assign sr_frame_overrun = overrun_q;

endmodule

// File: tb/tb_mixer_frame_scheduler.sv
// Directed bench for mixer_frame_scheduler with an ideal external multiplier
// and a frame-level arithmetic model feeding a DAC scoreboard.
module tb_mixer_frame_scheduler;
    localparam int AW = 24;
    localparam int GW = 32;
    localparam int Q  = 16;
    localparam int N  = 3;
    localparam int ONE = 65536;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fs_strobe = 1'b0;
    logic [N*AW-1:0]   channel_data;
    logic [N*GW-1:0]   cr_channel_gain;
    logic [N-1:0]      cr_channel_pan;
    logic [GW-1:0]     cr_output_gain;
    logic              cmd_clear_status = 1'b0;
    logic              mul_req_valid;
    logic              mul_req_ready;
    logic [GW-1:0]     mul_req_a, mul_req_b;
    logic              mul_rsp_valid;
    logic [GW-1:0]     mul_rsp_data;
    logic [AW-1:0]     dac_data;
    logic              dac_valid;
    logic              dac_ready;
    logic              dac_last;
    logic              busy, sr_out_clip, sr_frame_overrun;

    int  data_v[N];
    int  gain_v[N];
    bit  pan_v[N];
    int  ogain_v;
    logic mul_ready_en = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { int data; bit last; } dac_exp_t;
    dac_exp_t exp_q[$];
    int exp_l, exp_r;
    bit exp_clip;
    int got_l, got_r;

    always #5 clk = ~clk;

    mixer_frame_scheduler #(
        .AUDIO_WIDTH_P(AW), .GAIN_WIDTH_P(GW), .Q_BITS_P(Q), .NR_OF_CHANNELS_P(N)
    ) dut (
        .clk(clk), .rst(rst), .fs_strobe(fs_strobe),
        .channel_data(channel_data), .cr_channel_gain(cr_channel_gain),
        .cr_channel_pan(cr_channel_pan), .cr_output_gain(cr_output_gain),
        .cmd_clear_status(cmd_clear_status),
        .mul_req_valid(mul_req_valid), .mul_req_ready(mul_req_ready),
        .mul_req_a(mul_req_a), .mul_req_b(mul_req_b),
        .mul_rsp_valid(mul_rsp_valid), .mul_rsp_data(mul_rsp_data),
        .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
        .dac_last(dac_last), .busy(busy), .sr_out_clip(sr_out_clip),
        .sr_frame_overrun(sr_frame_overrun)
    );

    always_comb begin
        channel_data    = '0;
        cr_channel_gain = '0;
        cr_channel_pan  = '0;
        for (int i = 0; i < N; i++) begin
            channel_data[i*AW +: AW]    = data_v[i][AW-1:0];
            cr_channel_gain[i*GW +: GW] = gain_v[i];
            cr_channel_pan[i]           = pan_v[i];
        end
        cr_output_gain = ogain_v;
    end
    assign mul_req_ready = mul_ready_en;

    // (a*b)>>>Q truncated to a 32-bit signed word, as the multiplier returns.
    function automatic int mul_q(longint a, longint b);
        longint p;
        p = (a * b) >>> Q;
        return int'(p);
    endfunction

    function automatic longint clamp(longint v, int w, inout bit clipped);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) begin clipped = 1'b1; return hi; end
        if (v < lo) begin clipped = 1'b1; return lo; end
        return v;
    endfunction

    // Frame-level model: mix, apply master gain, saturate.
    function automatic void model_frame();
        longint al, ar;
        bit c;
        al = 0; ar = 0; c = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pan_v[i]) ar += mul_q(data_v[i], gain_v[i]);
            else          al += mul_q(data_v[i], gain_v[i]);
        end
        exp_l = int'(clamp(mul_q(clamp(al, GW, c), ogain_v), AW, c));
        exp_r = int'(clamp(mul_q(clamp(ar, GW, c), ogain_v), AW, c));
        exp_clip = c;
        exp_q.push_back('{exp_l, 1'b0});
        exp_q.push_back('{exp_r, 1'b1});
    endfunction

    // Ideal multiplier: always-ready (unless stalled), response one cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_rsp_valid <= 1'b0;
            mul_rsp_data  <= '0;
        end else begin
            mul_rsp_valid <= mul_req_valid && mul_req_ready;
            mul_rsp_data  <= mul_q(longint'($signed(mul_req_a)), longint'($signed(mul_req_b)));
        end
    end

    task automatic check(string name, longint act, longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DAC scoreboard plus hold-while-stalled checks.
    bit m_stall, d_stall;
    logic [GW-1:0] pa, pb;
    logic [AW-1:0] pd;
    logic pl;
    always @(negedge clk) begin
        if (rst) begin
            m_stall = 1'b0;
            d_stall = 1'b0;
        end else begin
            if (m_stall) begin
                check("mul_hold_valid", mul_req_valid, 1);
                check("mul_hold_a", mul_req_a, pa);
                check("mul_hold_b", mul_req_b, pb);
            end
            if (d_stall) begin
                check("dac_hold_valid", dac_valid, 1);
                check("dac_hold_data", dac_data, pd);
                check("dac_hold_last", dac_last, pl);
            end
            if (dac_valid && dac_ready) begin
                if (exp_q.size() == 0) begin
                    check("dac_unexpected", 1, 0);
                end else begin
                    dac_exp_t e;
                    e = exp_q.pop_front();
                    check("dac_data", longint'($signed(dac_data)), e.data);
                    check("dac_last", dac_last, e.last);
                    if (e.last) got_r = int'($signed(dac_data));
                    else        got_l = int'($signed(dac_data));
                end
            end
            m_stall = mul_req_valid && !mul_req_ready;
            d_stall = dac_valid && !dac_ready;
            pa = mul_req_a; pb = mul_req_b; pd = dac_data; pl = dac_last;
        end
    end

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_frame(int d0, int d1, int d2, int g0, int g1, int g2,
                             bit p0, bit p1, bit p2, int og);
        data_v[0] = d0; data_v[1] = d1; data_v[2] = d2;
        gain_v[0] = g0; gain_v[1] = g1; gain_v[2] = g2;
        pan_v[0] = p0;  pan_v[1] = p1;  pan_v[2] = p2;
        ogain_v = og;
    endtask

    // Pulse fs_strobe for one cycle; returns just after the sampling edge.
    task automatic strobe();
        model_frame();
        fs_strobe = 1'b1;
        tick(1);
        fs_strobe = 1'b0;
    endtask

    task automatic wait_done(string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin tick(1); n++; end
        if (n >= 200) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic check_all_zero(string name);
        check({name, "_mul_valid"}, mul_req_valid, 0);
        check({name, "_mul_a"}, mul_req_a, 0);
        check({name, "_mul_b"}, mul_req_b, 0);
        check({name, "_dac_valid"}, dac_valid, 0);
        check({name, "_dac_data"}, dac_data, 0);
        check({name, "_dac_last"}, dac_last, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_clip"}, sr_out_clip, 0);
        check({name, "_overrun"}, sr_frame_overrun, 0);
    endtask

    initial begin
        int n;
        dac_ready = 1'b1;
        set_frame(1000, -2000, 500, ONE, ONE, ONE, 0, 0, 1, ONE);
        #1;
        check_all_zero("reset");
        tick(3);
        rst = 1'b0;
        tick(2);

        // 1: basic frame and first-sample latency
        strobe();
        check("model_t1_l", exp_l, -1000);
        check("model_t1_r", exp_r, 500);
        n = 1;
        while (!dac_valid && n < 40) begin tick(1); n++; end
        check("first_dac_latency", n, 11);
        wait_done("t1");
        check("t1_l", got_l, -1000);
        check("t1_r", got_r, 500);
        check("t1_clip", sr_out_clip, 0);
        tick(2);

        // 2: output saturation and sticky clear
        set_frame(8388607, 0, 0, 2 * ONE, ONE, ONE, 0, 0, 1, ONE);
        strobe();
        check("model_t2_l", exp_l, 8388607);
        check("model_t2_clip", exp_clip, 1);
        wait_done("t2");
        check("t2_l", got_l, 8388607);
        check("t2_clip_set", sr_out_clip, 1);
        cmd_clear_status = 1'b1;
        tick(1);
        cmd_clear_status = 1'b0;
        check("t2_clip_cleared", sr_out_clip, 0);
        tick(2);

        // 3: strobe while busy is dropped; set beats simultaneous clear
        set_frame(1000, -2000, 500, ONE, ONE, ONE, 0, 0, 1, ONE);
        strobe();
        tick(2);
        fs_strobe = 1'b1;
        cmd_clear_status = 1'b1;
        tick(1);
        fs_strobe = 1'b0;
        cmd_clear_status = 1'b0;
        check("t3_overrun_set", sr_frame_overrun, 1);
        wait_done("t3");
        tick(20);
        check("t3_l", got_l, -1000);
        check("t3_r", got_r, 500);
        check("t3_idle", busy, 0);
        cmd_clear_status = 1'b1;
        tick(1);
        cmd_clear_status = 1'b0;
        check("t3_overrun_cleared", sr_frame_overrun, 0);

        // 4: multiplier and DAC backpressure
        mul_ready_en = 1'b0;
        dac_ready = 1'b0;
        strobe();
        tick(4);
        mul_ready_en = 1'b1;
        n = 0;
        while (!dac_valid && n < 60) begin tick(1); n++; end
        check("t4_dac_reached", dac_valid, 1);
        tick(4);
        dac_ready = 1'b1;
        wait_done("t4");
        check("t4_l", got_l, -1000);
        check("t4_r", got_r, 500);
        tick(2);

        // 5: reset in OUT_RSP aborts the frame
        strobe();
        tick(7);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(2);
        got_l = 0; got_r = 0;
        strobe();
        wait_done("t5");
        check("t5_l", got_l, -1000);
        check("t5_r", got_r, 500);
        tick(2);

        // 6: configuration change after the strobe affects only the next frame
        strobe();
        gain_v[0] = 0;
        wait_done("t6a");
        check("t6_first_l", got_l, -1000);
        tick(2);
        strobe();
        check("model_t6_l", exp_l, -2000);
        wait_done("t6b");
        check("t6_second_l", got_l, -2000);
        check("t6_second_r", got_r, 500);

        check("leftover_expected", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
